// File: rtl/rr_grant_enc_pkg.sv
// Shared helpers for the round-robin grant encoder: index sizing and
// modulo-N increment used by both the pointer update and the search base.
package rr_grant_enc_pkg;

  localparam int DEFAULT_N = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Explicit compare against n-1 so non-power-of-two port counts wrap correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_grant_enc_onehot_enc.sv
// Combinational one-hot to binary index encoder; all-zero or multi-hot
// inputs encode to 0 and raise err.
module onehot_enc
  import rr_grant_enc_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int IDXW = clog2_min1(N)
) (
  input  logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            err
);

  logic [IDXW-1:0] acc;
  int              cnt;

  always_comb begin
    acc = '0;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        acc = acc | IDXW'(i);
        cnt = cnt + 1;
      end
    end
    err = (cnt != 1);
    idx = err ? '0 : acc;
  end

endmodule

// File: rtl/rr_grant_enc.sv
// Round-robin (or fixed-priority) arbiter with a registered one-hot grant,
// its binary index and a valid/ready output handshake.
module rr_grant_enc
  import rr_grant_enc_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int IDXW = clog2_min1(N),
  parameter bit RR   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            out_ready,
  output logic            grant_valid,
  output logic [N-1:0]    grant_onehot,
  output logic [IDXW-1:0] grant_idx,
  output logic            enc_err
);

  logic            grant_valid_q, grant_valid_d;
  logic [N-1:0]    grant_onehot_q, grant_onehot_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            enc_err_q, enc_err_d;

  logic            fire, free, found, load, enc_err_w;
  logic [N-1:0]    eff_req, winner;
  int              base, p;

  always_comb begin
    fire    = grant_valid_q & out_ready;
    free    = ~grant_valid_q | fire;
    // The port just served cannot win again off the same held request.
    eff_req = req & ~(fire ? grant_onehot_q : '0);
    if (RR) base = fire ? wrap_inc(int'(grant_idx_q), N) : int'(ptr_q);
    else    base = 0;

    winner = '0;
    found  = 1'b0;
    p      = 0;
    for (int k = 0; k < N; k++) begin
      p = base + k;
      if (p >= N) p = p - N;
      if (!found && eff_req[p]) begin
        winner[p] = 1'b1;
        found     = 1'b1;
      end
    end

    load           = free & found;
    grant_valid_d  = free ? found : grant_valid_q;
    grant_onehot_d = free ? winner : grant_onehot_q;
    ptr_d          = fire ? IDXW'(wrap_inc(int'(grant_idx_q), N)) : ptr_q;
    enc_err_d      = enc_err_q | (load & enc_err_w);
  end

  onehot_enc #(.N(N), .IDXW(IDXW)) u_enc (
    .onehot (grant_onehot_d),
    .idx    (grant_idx_d),
    .err    (enc_err_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
      grant_idx_q    <= '0;
      ptr_q          <= '0;
      enc_err_q      <= 1'b0;
    end else begin
      grant_valid_q  <= grant_valid_d;
      grant_onehot_q <= grant_onehot_d;
      grant_idx_q    <= grant_idx_d;
      ptr_q          <= ptr_d;
      enc_err_q      <= enc_err_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_onehot = grant_onehot_q;
  assign grant_idx    = grant_idx_q;
  assign enc_err      = enc_err_q;

endmodule

// File: tb/tb_rr_grant_enc.sv
// Bench for rr_grant_enc: three instances (N=32 RR, N=5 RR, N=32 fixed
// priority) checked every cycle against a modulo-arithmetic arbiter model.
module tb_rr_grant_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] req32, reqfp;
  logic [4:0]  req5;
  logic        rdy32, rdy5, rdyfp;

  logic        v32, vfp, v5;
  logic [31:0] oh32, ohfp;
  logic [4:0]  oh5;
  logic [4:0]  idx32, idxfp;
  logic [2:0]  idx5;
  logic        err32, errfp, err5;

  rr_grant_enc #(.N(32), .RR(1'b1)) d32 (
    .clk(clk), .rst(rst), .req(req32), .out_ready(rdy32),
    .grant_valid(v32), .grant_onehot(oh32), .grant_idx(idx32), .enc_err(err32));

  rr_grant_enc #(.N(5), .RR(1'b1)) d5 (
    .clk(clk), .rst(rst), .req(req5), .out_ready(rdy5),
    .grant_valid(v5), .grant_onehot(oh5), .grant_idx(idx5), .enc_err(err5));

  rr_grant_enc #(.N(32), .RR(1'b0)) dfp (
    .clk(clk), .rst(rst), .req(reqfp), .out_ready(rdyfp),
    .grant_valid(vfp), .grant_onehot(ohfp), .grant_idx(idxfp), .enc_err(errfp));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbiter model: one step of grant/hold/release behaviour per clock.
  function automatic void mstep(input int n, input bit rr, input logic [31:0] rq,
                                input bit rdy, inout bit v, inout int idx, inout int ptr);
    bit          fire;
    int          base, pos;
    bit          got;
    logic [31:0] e;
    fire = v && rdy;
    e    = rq;
    if (fire) e[idx] = 1'b0;
    if (!v || fire) begin
      if (!rr)       base = 0;
      else if (fire) base = (idx + 1) % n;
      else           base = ptr;
      if (fire) ptr = (idx + 1) % n;
      v   = 1'b0;
      idx = 0;
      got = 1'b0;
      for (int k = 0; k < n; k++) begin
        pos = (base + k) % n;
        if (!got && e[pos]) begin
          got = 1'b1;
          v   = 1'b1;
          idx = pos;
        end
      end
    end
  endfunction

  function automatic logic [31:0] ohx(input bit v, input int i);
    return v ? (32'd1 << i) : 32'd0;
  endfunction

  bit mv0, mv1, mv2;
  int mi0, mi1, mi2, mp0, mp1, mp2;

  always @(posedge clk) begin
    if (rst) begin
      mv0 = 0; mi0 = 0; mp0 = 0;
      mv1 = 0; mi1 = 0; mp1 = 0;
      mv2 = 0; mi2 = 0; mp2 = 0;
    end else begin
      mstep(32, 1'b1, req32, rdy32, mv0, mi0, mp0);
      mstep(5, 1'b1, {27'd0, req5}, rdy5, mv1, mi1, mp1);
      mstep(32, 1'b0, reqfp, rdyfp, mv2, mi2, mp2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m32_valid", v32, mv0);
      chk("m32_onehot", oh32, ohx(mv0, mi0));
      chk("m32_idx", idx32, mi0);
      chk("m32_err", err32, 0);
      chk("m5_valid", v5, mv1);
      chk("m5_onehot", oh5, ohx(mv1, mi1));
      chk("m5_idx", idx5, mi1);
      chk("m5_err", err5, 0);
      chk("mfp_valid", vfp, mv2);
      chk("mfp_onehot", ohfp, ohx(mv2, mi2));
      chk("mfp_idx", idxfp, mi2);
      chk("mfp_err", errfp, 0);
    end
  end

  int rr_exp[5] = '{0, 4, 31, 0, 4};
  int w5_exp[4] = '{0, 4, 0, 4};
  int fp_exp[4] = '{8, 9, 8, 9};

  initial begin
    rst = 1'b1;
    req32 = '0; req5 = '0; reqfp = '0;
    rdy32 = 1'b0; rdy5 = 1'b0; rdyfp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", v32, 0);
    chk("rst_onehot", oh32, 0);
    chk("rst_idx", idx32, 0);
    chk("rst_err", err32, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", v32, 0);

    // Round-robin rotation over bits 0, 4, 31.
    req32 = 32'h8000_0011; rdy32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_idx", idx32, rr_exp[i]);
      chk("rr_valid", v32, 1);
    end
    req32 = '0;
    repeat (2) @(negedge clk);

    // Back-pressure: grant held while stalled, even after req drops.
    rdy32 = 1'b0; req32 = 32'h0000_0006;
    @(negedge clk);
    chk("bp_idx", idx32, 1);
    chk("bp_onehot", oh32, 32'h2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req32 = '0;
      @(negedge clk);
      chk("bp_hold_idx", idx32, 1);
      chk("bp_hold_onehot", oh32, 32'h2);
      chk("bp_hold_valid", v32, 1);
    end
    rdy32 = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", v32, 0);
    @(negedge clk);
    chk("bp_after_valid", v32, 0);

    // Single held request: granted on alternating cycles only.
    req32 = 32'h0000_0080;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_valid", v32, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk("b2b_idx", idx32, 7);
    end
    req32 = '0;
    repeat (2) @(negedge clk);

    // Non-power-of-two wrap.
    req5 = 5'b10001; rdy5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("n5_idx", idx5, w5_exp[i]);
      chk("n5_valid", v5, 1);
    end
    req5 = '0;
    repeat (2) @(negedge clk);

    // Fixed priority with served-bit masking.
    reqfp = 32'h0000_0300; rdyfp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fp_idx", idxfp, fp_exp[i]);
    end
    reqfp = '0;
    repeat (2) @(negedge clk);

    // Reset mid-stall drops the grant and leaves ptr at 0.
    rdy32 = 1'b0; req32 = 32'h0000_0008;
    @(negedge clk);
    chk("stall_load_idx", idx32, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", v32, 0);
    chk("midrst_onehot", oh32, 0);
    chk("midrst_idx", idx32, 0);
    rst = 1'b0; req32 = '0;
    @(negedge clk);
    chk("postrst_valid", v32, 0);
    rdy32 = 1'b1; req32 = 32'h0000_0404;
    @(negedge clk);
    chk("postrst_ptr_idx", idx32, 2);
    req32 = '0;
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_grant_enc.md
# rr_grant_enc

Parametrised round-robin arbiter with a registered one-hot grant and its binary index, plus a valid/ready output handshake. It sits between N requesting ports (default 32) and a single shared resource, and replaces standalone one-hot-to-index decoding wherever the one-hot vector comes from an arbitration decision. It adds fairness, back-pressure and a stalled-grant hold. It also supports non-power-of-two port counts.

## Interface
- N, 32, number of requesters; legal range 2..256.
- IDXW, $clog2(N), width of the encoded index.
- RR, 1, arbitration mode: 1 selects round-robin, 0 selects fixed priority with the lowest index winning.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- req  input  N  request vector; bit i requests port i.
- out_ready  input  1  consumer accepts the current grant.
- grant_valid  output  1  a grant is held in the output register.
- grant_onehot  output  N  the held grant; exactly one bit is set when grant_valid is 1, otherwise all zero.
- grant_idx  output  IDXW  binary index of grant_onehot; 0 when grant_valid is 0.
- enc_err  output  1  registered flag: the internal encoder saw a non-one-hot vector while a grant was loaded. Should never assert; used for bench checks only.

## Operation
- Internal state:
  - ptr[IDXW-1:0], the round-robin base.
  - The output register: grant_valid, grant_onehot, grant_idx.
- Handshake:
  - fire = grant_valid & out_ready.
  - The output register is free when grant_valid == 0 or fire == 1.
- Load:
  - When the register is free and the effective request vector is non-zero, the winner is loaded and grant_valid is set to 1.
  - If the register is free and there is no effective request, grant_valid is cleared to 0 and grant_onehot and grant_idx are cleared to 0.
- Effective request:
  - Equals req, except that on a fire cycle the bit at grant_idx is masked to 0.
  - This guarantees the just-served port is not granted twice back-to-back off the same held request.
- Winner, RR = 1:
  - The first set bit of the effective request, scanning upward from the search base with wrap from N-1 to 0.
  - Search base: (grant_idx + 1) mod N on a fire cycle; ptr otherwise.
- Winner, RR = 0: the lowest set bit of the effective request; ptr is unused.
- Pointer update:
  - On fire, ptr <= (grant_idx + 1) mod N.
  - The wrap is explicit compare-to-(N-1), not power-of-two truncation, so non-power-of-two N is correct.
- Stall: while grant_valid & !out_ready, grant_onehot and grant_idx are held constant, whatever req does. Requests may deassert or change without retracting the held grant.
- grant_idx is produced by the onehot_enc sub-module from the next-state one-hot vector. An all-zero or multi-hot vector encodes to 0 (legacy behaviour), and enc_err is set when that happens during a load.
- Reset:
  - grant_valid = 0, grant_onehot = 0, grant_idx = 0, enc_err = 0, ptr = 0.
  - A reset asserted mid-stall discards the held grant; ptr is not advanced for it.

## Timing
- Latency: req rising at edge k gives grant_valid at edge k+1 (one register stage). There is no combinational path from req to any output.
- Throughput: one grant per cycle while out_ready stays 1 and requests are present.
- out_ready affects only the next-state logic; outputs are registered only.
- Critical path: masked priority search over N bits (double-width or thermometer-mask scheme), then the encoder. Target single cycle at N = 32.

## Structure
- Shared package (hydra_pkg):
  - onehot_err_t is not needed.
  - Add a localparam function clog2_min1(n), which returns at least 1.
  - Add a function wrap_inc(idx, n), used for both the ptr update and the search base.
- One sub-module, onehot_enc: parameter N, input onehot[N], outputs idx[IDXW] and err.
  - Combinational.
  - It is the parametrised generalisation of the 32-way one-hot decoder.
  - It is instantiated once, on the next-state grant vector.

## Test plan
- Reset then idle, with req = 0 and rst pulsed mid-run → every output is 0 one cycle after the rst edge, and grant_valid stays 0.
- Round-robin: N = 32, RR = 1, req = 32'h8000_0011, out_ready = 1 held → grant_idx sequence 0, 4, 31, 0, 4, with grant_valid continuously 1.
- Back-pressure: req = 32'h0000_0006, out_ready = 0 for 5 cycles, then req changes to 0 → grant_idx stays 1 and grant_onehot stays 32'h2 through the stall. When out_ready rises it fires once, then grant_valid drops to 0.
- Back-to-back mask: only req[7] = 1 held, out_ready = 1 → grants at idx 7 on alternating cycles (the fire cycle masks bit 7), never on two consecutive cycles.
- Wrap and non-power-of-two: N = 5, RR = 1, req = 5'b10001 → idx 0, 4, 0, 4. ptr wraps 4 → 0, and grant_idx never exceeds 4.
- Fixed priority: RR = 0, req = 32'h0000_0300 held, out_ready = 1 → grant_idx alternates 8, 9 (bit 8 masked on its fire cycle). enc_err stays 0 in all tests.
